// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-side arbiter.
//   arb_state_e : arbiter state (IDLE between bursts, BURST while a grant is owned)
//   TRUNC_SAT   : saturation value of the truncation counter
//   gid_bits    : width of a requester index for a given requester count
//   gray2bin    : Gray-to-binary conversion of the low 'width' bits of a pointer
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    localparam logic [7:0] TRUNC_SAT = 8'hFF;

    function automatic int unsigned gid_bits(input int unsigned n);
        if (n <= 1) begin
            return 1;
        end
        return $clog2(n);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it, so XOR-ing
    // every right shift of the masked pointer yields the binary value.
    function automatic logic [31:0] gray2bin(input logic [31:0] gray, input int unsigned width);
        logic [31:0] mask;
        logic [31:0] g;
        logic [31:0] bin;
        mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'h1 << width) - 32'h1);
        g    = gray & mask;
        bin  = g;
        for (int i = 1; i < 32; i++) begin
            bin = bin ^ (g >> i);
        end
        return bin;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester and FIFO write-port bundle of the write-side arbiter.
//   req_valid/req_last/req_data : per-requester beat stream (data packed, requester i at [i*DAT_BIT +: DAT_BIT])
//   req_ready                   : per-requester beat accept
//   fifo_wptr_gray              : FIFO write pointer, Gray-coded
//   fifo_sync_rptr_gray         : read pointer synchronised into the write domain, Gray-coded
//   fifo_full                   : FIFO full flag
//   fifo_wr_en/fifo_wr_data     : FIFO write strobe and data
// master: requesters plus FIFO side; slave: the arbiter.
interface fifo_wr_arbiter_if #(
    parameter int N_REQ   = 4,
    parameter int ADR_BIT = 4,
    parameter int PTR_BIT = ADR_BIT + 1,
    parameter int DAT_BIT = 32
);
    logic [N_REQ-1:0]         req_valid;
    logic [N_REQ-1:0]         req_last;
    logic [N_REQ*DAT_BIT-1:0] req_data;
    logic [N_REQ-1:0]         req_ready;
    logic [PTR_BIT-1:0]       fifo_wptr_gray;
    logic [PTR_BIT-1:0]       fifo_sync_rptr_gray;
    logic                     fifo_full;
    logic                     fifo_wr_en;
    logic [DAT_BIT-1:0]       fifo_wr_data;

    modport master (
        output req_valid, req_last, req_data,
        output fifo_wptr_gray, fifo_sync_rptr_gray, fifo_full,
        input  req_ready, fifo_wr_en, fifo_wr_data
    );

    modport slave (
        input  req_valid, req_last, req_data,
        input  fifo_wptr_gray, fifo_sync_rptr_gray, fifo_full,
        output req_ready, fifo_wr_en, fifo_wr_data
    );
endinterface

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational round-robin picker.
//   req   : request vector
//   last  : index of the previous owner; the search starts just after it
//   found : at least one request is set
//   sel   : first requesting index found from last+1, wrapping modulo N_REQ
module rr_picker #(
    parameter int N_REQ   = 4,
    parameter int GID_BIT = 2
) (
    input  logic [N_REQ-1:0]   req,
    input  logic [GID_BIT-1:0] last,
    output logic               found,
    output logic [GID_BIT-1:0] sel
);
    logic [GID_BIT-1:0] idx;

    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = GID_BIT'((int'(last) + k) % N_REQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Write-side controller for the async FIFO: shares the single write port among
// N_REQ requesters with round-robin arbitration and burst locking, derives the
// fill level and almost-full flag from the write-domain Gray pointers.
//   wr_clk, wr_rst_n : write clock, asynchronous active-low reset
//   bus              : requester streams and FIFO write port (slave modport)
//   grant_id         : current owner index
//   busy             : a burst is owned
//   afull            : registered almost-full flag (gates new grants only)
//   level            : registered fill level
//   trunc_cnt        : saturating count of bursts cut at MAX_BURST
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int ADR_BIT   = 4,
    parameter int PTR_BIT   = ADR_BIT + 1,
    parameter int DAT_BIT   = 32,
    parameter int MAX_BURST = 8,
    parameter int AFULL_LVL = 12,
    localparam int GID_BIT  = gid_bits(N_REQ)
) (
    input  logic                wr_clk,
    input  logic                wr_rst_n,
    fifo_wr_arbiter_if.slave    bus,
    output logic [GID_BIT-1:0]  grant_id,
    output logic                busy,
    output logic                afull,
    output logic [PTR_BIT-1:0]  level,
    output logic [7:0]          trunc_cnt
);
    arb_state_e         state;
    arb_state_e         state_nxt;
    logic [GID_BIT-1:0] last_owner;
    logic [GID_BIT-1:0] pick_id;
    logic               pick_found;
    logic [7:0]         beat_cnt;
    logic               grant_now;
    logic               beat;
    logic               owner_last;
    logic               cnt_at_max;
    logic               burst_end;
    logic               trunc_hit;
    logic [PTR_BIT-1:0] level_nxt;
    logic               afull_nxt;
    logic [DAT_BIT-1:0] req_words [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign req_words[g] = bus.req_data[g*DAT_BIT +: DAT_BIT];
    end

    rr_picker #(
        .N_REQ   (N_REQ),
        .GID_BIT (GID_BIT)
    ) u_picker (
        .req   (bus.req_valid),
        .last  (last_owner),
        .found (pick_found),
        .sel   (pick_id)
    );

    assign grant_now  = (state == IDLE) && pick_found && !afull;
    assign beat       = (state == BURST) && bus.req_valid[grant_id] && !bus.fifo_full;
    assign owner_last = bus.req_last[grant_id];
    assign cnt_at_max = (beat_cnt == 8'(MAX_BURST - 1));
    assign burst_end  = beat && (owner_last || cnt_at_max);
    // A beat that carries req_last is a normal end even when it also reaches MAX_BURST.
    assign trunc_hit  = beat && !owner_last && cnt_at_max;

    // Fill level: modulo subtraction of the binary pointers handles wrap naturally.
    assign level_nxt = PTR_BIT'(gray2bin(32'(bus.fifo_wptr_gray), PTR_BIT)
                              - gray2bin(32'(bus.fifo_sync_rptr_gray), PTR_BIT));
    assign afull_nxt = (int'(level_nxt) >= AFULL_LVL);

    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_now) state_nxt = BURST;
            BURST:   if (burst_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready    = '0;
        busy             = 1'b0;
        if (state == BURST) begin
            busy                    = 1'b1;
            bus.req_ready[grant_id] = !bus.fifo_full;
        end
        bus.fifo_wr_en   = beat;
        bus.fifo_wr_data = beat ? req_words[grant_id] : '0;
    end

    // Grant bookkeeping; the search for the next grant starts after the last owner.
    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            grant_id   <= '0;
            last_owner <= GID_BIT'(N_REQ - 1);
            beat_cnt   <= '0;
            trunc_cnt  <= '0;
        end else begin
            if (grant_now) begin
                grant_id <= pick_id;
                beat_cnt <= '0;
            end else if (beat) begin
                beat_cnt <= beat_cnt + 8'd1;
            end
            if (burst_end) begin
                last_owner <= grant_id;
            end
            if (trunc_hit && (trunc_cnt != TRUNC_SAT)) begin
                trunc_cnt <= trunc_cnt + 8'd1;
            end
        end
    end

    // Level and almost-full register together, one cycle behind the pointers.
    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            level <= '0;
            afull <= 1'b0;
        end else begin
            level <= level_nxt;
            afull <= afull_nxt;
        end
    end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Write-side controller for the team's async FIFO.
- Shares the single FIFO write port among N_REQ requesters using round-robin arbitration with burst locking.
- Derives fill level and an almost-full flag from the write-domain Gray pointers, and applies backpressure to requesters.
- Sits entirely in the FIFO write clock domain, directly in front of the FIFO write interface.

Parameters:
N_REQ, 4, number of requesters (2..8)
ADR_BIT, 4, FIFO address width; depth = 2**ADR_BIT
PTR_BIT, ADR_BIT+1, FIFO pointer width (Gray and binary)
DAT_BIT, 32, data width per requester
MAX_BURST, 8, maximum beats per grant before forced release (1..255)
AFULL_LVL, 12, fill level at or above which no new grant is issued

Ports:
wr_clk  in  1  write-domain clock; all logic is on the rising edge
wr_rst_n  in  1  asynchronous, active-low reset
req_valid  in  N_REQ  per-requester beat valid
req_last  in  N_REQ  per-requester end-of-burst marker, qualified by req_valid
req_data  in  N_REQ*DAT_BIT  packed per-requester data; requester i occupies [i*DAT_BIT +: DAT_BIT]
req_ready  out  N_REQ  per-requester beat accept
fifo_wptr_gray  in  PTR_BIT  FIFO write pointer, Gray-coded
fifo_sync_rptr_gray  in  PTR_BIT  read pointer synchronised into the write domain, Gray-coded
fifo_full  in  1  FIFO full flag
fifo_wr_en  out  1  FIFO write strobe
fifo_wr_data  out  DAT_BIT  FIFO write data
grant_id  out  $clog2(N_REQ)  current owner index
busy  out  1  high while a burst is owned
afull  out  1  registered almost-full flag
level  out  PTR_BIT  registered fill level
trunc_cnt  out  8  saturating count of bursts truncated at MAX_BURST

Behaviour:
- Reset (async assert, sync deassert expected externally):
  - state=IDLE, grant_id=0, last owner=N_REQ-1 (first search starts at requester 0).
  - beat counter=0; level=0, afull=0, trunc_cnt=0.
  - req_ready, fifo_wr_en, busy all 0.
- Level and almost-full:
  - level = gray2bin(wptr) - gray2bin(sync_rptr), modulo 2**PTR_BIT, registered; 1-cycle latency.
  - afull = (next level >= AFULL_LVL), registered in the same cycle as level.
  - Correct across pointer wrap, e.g. wptr bin 2, rptr bin 30, PTR_BIT=5 gives level=4.
- IDLE state:
  - No ready outputs asserted.
  - If any req_valid and !afull: pick the first valid requester searching from last_owner+1 modulo N_REQ.
  - Register that requester into grant_id, clear the beat counter, go to BURST.
  - Arbitration costs one cycle; the first beat can be accepted one cycle after the grant decision.
- BURST state:
  - busy=1.
  - req_ready[grant_id] = !fifo_full; all other ready outputs are 0.
  - beat = req_valid[grant_id] & req_ready[grant_id].
  - fifo_wr_en = beat and fifo_wr_data = owner's data slice; combinational, zero latency.
  - Each beat increments the beat counter.
- Leaving BURST:
  - A beat with req_last ends the burst: go to IDLE, last_owner = grant_id.
  - A beat that brings the count to MAX_BURST without req_last also ends the burst: go to IDLE and increment trunc_cnt (saturates at 255). The requester later continues its burst under a new grant.
  - If both conditions hit on the same beat, it counts as a normal end; no truncation is recorded.
- Boundary cases:
  - Owner drops req_valid mid-burst: the grant is held and no beat occurs; there is no timeout.
  - fifo_full mid-burst: the grant is held, ready is 0, no write occurs.
  - afull only gates new grants; it never aborts an active burst.
  - Every burst end passes through one IDLE cycle, so back-to-back grants have a 1-cycle bubble.
  - fifo_wr_en is never asserted while fifo_full=1.
  - Reset mid-burst: the burst is dropped immediately and outputs return to their reset values.

Decomposition:
- Package fifo_arb_pkg:
  - state enum (IDLE, BURST);
  - gray2bin function, parameterised by width;
  - localparam GID_BIT = $clog2(N_REQ) helper.
- One sub-module, rr_picker: combinational round-robin picker.
  - Inputs: request vector, last-owner index.
  - Outputs: found flag, selected index.
- Everything else (state, counters, level, datapath mux) lives in the top module.

Test Plan:
- Single requester 0 sends a 3-beat burst, FIFO empty: grant at cycle 1, three fifo_wr_en pulses with data 0xA0, 0xA1, 0xA2, busy falls after the last beat, trunc_cnt=0.
- All 4 requesters hold valid with 2-beat bursts: grant order is 0,1,2,3,0, with one IDLE cycle between bursts.
- Requester 2 sends a 20-beat burst with MAX_BURST=8: grants of 8, 8 and 4 beats, trunc_cnt=2; another waiting requester is served between the pieces.
- fifo_full asserted for 3 cycles in the middle of a burst: req_ready and fifo_wr_en are 0 for exactly those 3 cycles, no data is lost, and the grant is kept.
- Pointers wptr bin 14, rptr bin 2 (level 12): afull=1 and no new grant is issued; when rptr moves to bin 3, afull falls the next cycle and the grant follows. Also wrap check: wptr bin 2, rptr bin 30 gives level=4.
- wr_rst_n asserted low mid-burst: all outputs go to 0 immediately; after release, arbitration restarts at requester 0.
